key_event_queue: RTL and testbench
==================================

// Module: key_event_queue
// PURPOSE
//  Consumer end of the debounced-key interface: takes the 4-bit, active-high,
//  one-cycle key pulses produced by the key debouncer (clk1k domain) and
//  serialises them into a queue of 2-bit key codes. A valid/ready handshake
//  delivers the codes to the vending control FSM, so no press is lost while
//  the FSM is busy. Overflow is flagged and counted rather than silently dropped.
// PARAMETERS
//  DEPTH    4   FIFO entries, power of two, minimum 2
//  AW       2   log2(DEPTH), FIFO pointer width
//  DROP_W   8   width of the saturating drop counter
// PORTS
//  clk1k      in   1       1 kHz system clock, all logic on the rising edge
//  clr        in   1       synchronous reset, active low
//  key_pulse  in   4       debounced pulses, bit i high for 1 cycle = key i pressed
//  evt_valid  out  1       head-of-queue code is valid
//  evt_code   out  2       key index of the head event (0..3)
//  evt_ready  in   1       consumer accepts the head event this cycle
//  evt_cnt    out  AW+1    entries currently held in the FIFO (0..DEPTH)
//  evt_ovf    out  1       sticky overflow flag
//  ovf_clr    in   1       clears evt_ovf and drop_cnt (lower priority than clr)
//  drop_cnt   out  DROP_W  presses lost, saturates at all-ones
// BEHAVIOUR
//  Reset (clr==0 at an edge): pending=0, FIFO empty, evt_valid=0, evt_code=0,
//   evt_cnt=0, evt_ovf=0, drop_cnt=0. A reset mid-drain discards all queued and
//   pending events. key_pulse sampled in the reset cycle is ignored.
//  Pending stage: 4-bit reg pending. Per cycle:
//   grant = one-hot of the lowest set bit of pending, gated by push_ok.
//   pending <= (pending & ~grant) | key_pulse.
//  push_ok = (evt_cnt < DEPTH) || (evt_valid && evt_ready).
//   Push/pop in the same cycle is legal when full; evt_cnt stays unchanged.
//  Push: when grant != 0, write the index of the granted bit into the FIFO.
//   At most one push per cycle. Simultaneous pulses drain in ascending index order.
//  Pop: when evt_valid && evt_ready, advance the read pointer.
//   evt_ready while !evt_valid has no effect.
//  Latency: pulse at edge E0 -> pending set after E0 -> written at E1 ->
//   evt_valid=1 with evt_code after E1 (2 edges, empty queue, no competition).
//  Output: evt_code = FIFO head (registered storage, no bypass path).
//   Stable while evt_valid && !evt_ready.
//   evt_valid = (evt_cnt != 0).
//  Overflow: key_pulse[i] arrives while pending[i]==1 and bit i is not granted
//   in that cycle -> that press is lost. Set evt_ovf; drop_cnt += popcount of
//   lost bits, saturating. Pending bits are never discarded while the FIFO is
//   full; they wait.
//   ovf_clr in the same cycle as a new loss: the loss wins (evt_ovf=1,
//   drop_cnt = number of bits lost in that cycle).
//  Pointers wrap modulo DEPTH. evt_cnt is exact: +1 push only, -1 pop only.
// STRUCTURE
//  Shared package: KEY_NUM=4, KEY_CW=2, and localparams for the key index
//   encoding (KEY_COIN1=0, KEY_COIN5=1, KEY_SEL=2, KEY_CANCEL=3) shared with
//   the vending FSM.
//  Sub-module key_fifo: synchronous FIFO (DEPTH x 2 bit) with push/pop, count,
//   and synchronous active-low clr. Used by this block only.
//  This module keeps the pending register, the priority grant, and the
//   overflow/drop logic.
// TESTING
//  1 Single press: key_pulse=4'b0100 for 1 cycle, evt_ready=1 -> evt_valid high
//    2 edges later for exactly 1 cycle, evt_code=2, evt_cnt returns to 0.
//  2 Simultaneous press: key_pulse=4'b1011, evt_ready=0 -> evt_cnt reaches 3;
//    then evt_ready=1 -> codes 0,1,3 delivered on consecutive cycles.
//  3 Full queue: evt_ready=0, pulses on keys 0,1,2,3 in separate cycles, then
//    key 0 again (pending) and key 0 once more -> evt_cnt=4, evt_ovf=1,
//    drop_cnt=1; after evt_ready=1, five codes out: 0,1,2,3,0.
//  4 Full push/pop: queue full with key 1 pending, evt_ready=1 for one cycle ->
//    pop and push in the same cycle, evt_cnt stays 4, pending[1] clears.
//  5 Reset mid-drain: 3 events queued, clr=0 for 1 cycle -> all outputs at reset
//    values next edge; a key_pulse in the reset cycle produces no event.
//  6 Saturation: force 300 losses -> drop_cnt=255; ovf_clr=1 -> drop_cnt=0,
//    evt_ovf=0.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared key encoding for the debounced-key path and the vending control FSM.
package key_event_queue_pkg;

    localparam int KEY_NUM = 4;
    localparam int KEY_CW  = 2;

    localparam logic [KEY_CW-1:0] KEY_COIN1  = 2'd0;
    localparam logic [KEY_CW-1:0] KEY_COIN5  = 2'd1;
    localparam logic [KEY_CW-1:0] KEY_SEL    = 2'd2;
    localparam logic [KEY_CW-1:0] KEY_CANCEL = 2'd3;

    // Index of the lowest set bit; lower keys win simultaneous presses.
    function automatic logic [KEY_CW-1:0] lowest_key(input logic [KEY_NUM-1:0] bits);
        lowest_key = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (bits[i]) lowest_key = KEY_CW'(i);
        end
    endfunction

    function automatic logic [KEY_CW:0] key_popcount(input logic [KEY_NUM-1:0] bits);
        key_popcount = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            key_popcount = key_popcount + {{KEY_CW{1'b0}}, bits[i]};
        end
    endfunction

endpackage

// File: rtl/key_event_queue_key_fifo.sv
// Small synchronous FIFO of key codes; the caller guarantees push/pop legality.
module key_fifo
    import key_event_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk1k,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [KEY_CW-1:0] din,
    output logic [KEY_CW-1:0] head,
    output logic [AW:0]       count
);

    logic [KEY_CW-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is cleared too so the head code reads zero out of reset.
    always_ff @(posedge clk1k) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/key_event_queue.sv
// Serialises one-cycle key pulses into a queue of key codes with a valid/ready
// handshake; presses that cannot be held are flagged and counted.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int DROP_W = 8
) (
    input  logic              clk1k,
    input  logic              clr,
    input  logic [KEY_NUM-1:0] key_pulse,
    output logic              evt_valid,
    output logic [KEY_CW-1:0] evt_code,
    input  logic              evt_ready,
    output logic [AW:0]       evt_cnt,
    output logic              evt_ovf,
    input  logic              ovf_clr,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [KEY_NUM-1:0] pending;
    logic [KEY_NUM-1:0] grant;
    logic [KEY_NUM-1:0] lost;
    logic [KEY_CW-1:0]  grant_idx;
    logic               push_ok;
    logic               push;
    logic               pop;
    logic [DROP_W:0]    drop_sum;

    assign evt_valid = (evt_cnt != '0);
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = (evt_cnt < (AW+1)'(DEPTH)) || pop;
    assign grant_idx = lowest_key(pending);
    assign push      = push_ok && (pending != '0);
    assign grant     = push ? (KEY_NUM'(1) << grant_idx) : '0;
    // A repeat press on a key still waiting in pending has nowhere to go.
    assign lost      = key_pulse & pending & ~grant;

    always_comb begin
        drop_sum = (ovf_clr ? '0 : {1'b0, drop_cnt}) + (DROP_W+1)'(key_popcount(lost));
    end

    always_ff @(posedge clk1k) begin
        if (!clr) begin
            pending  <= '0;
            evt_ovf  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pending <= (pending & ~grant) | key_pulse;
            if (lost != '0) begin
                evt_ovf  <= 1'b1;
                drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end else if (ovf_clr) begin
                evt_ovf  <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    key_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk1k(clk1k),
        .clr  (clr),
        .push (push),
        .pop  (pop),
        .din  (grant_idx),
        .head (evt_code),
        .count(evt_cnt)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: expected codes are queued as keys are
// pressed and compared as the DUT hands events over.
module tb_key_event_queue;
    import key_event_queue_pkg::*;

    logic       clk1k = 1'b0;
    logic       clr;
    logic [3:0] key_pulse;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic [2:0] evt_cnt;
    logic       evt_ovf;
    logic       ovf_clr;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk1k = ~clk1k;

    key_event_queue #(
        .DEPTH (4),
        .AW    (2),
        .DROP_W(8)
    ) dut (
        .clk1k    (clk1k),
        .clr      (clr),
        .key_pulse(key_pulse),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_ready(evt_ready),
        .evt_cnt  (evt_cnt),
        .evt_ovf  (evt_ovf),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk1k);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] kp, input logic rdy, input logic oc, input int n);
        key_pulse = kp;
        evt_ready = rdy;
        ovf_clr   = oc;
        tick(n);
    endtask

    // Every accepted handshake must match the oldest outstanding expectation.
    always @(negedge clk1k) begin
        if (clr === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) checkOutput("sb_underflow", exp_q.size(), 1);
            else checkOutput("evt_code", evt_code, exp_q.pop_front());
        end
    end

    initial begin
        clr = 1'b0;
        key_pulse = '0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        tick(2);
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_code", evt_code, 0);
        checkOutput("rst_cnt", evt_cnt, 0);
        checkOutput("rst_ovf", evt_ovf, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        clr = 1'b1;

        // single press, two-edge latency, one-cycle valid
        exp_q.push_back(KEY_SEL);
        applyStimulus(4'b0100, 1, 0, 1);
        checkOutput("t1_valid_e0", evt_valid, 0);
        applyStimulus(4'b0000, 1, 0, 1);
        checkOutput("t1_valid_e1", evt_valid, 1);
        checkOutput("t1_code_e1", evt_code, KEY_SEL);
        applyStimulus(4'b0000, 1, 0, 1);
        checkOutput("t1_valid_e2", evt_valid, 0);
        checkOutput("t1_cnt_e2", evt_cnt, 0);

        // simultaneous press drains in ascending order
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        applyStimulus(4'b1011, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 3);
        checkOutput("t2_cnt", evt_cnt, 3);
        checkOutput("t2_head", evt_code, 0);
        applyStimulus(4'b0000, 1, 0, 3);
        checkOutput("t2_cnt_drained", evt_cnt, 0);

        // full queue plus a repeat press on a pending key
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        applyStimulus(4'b0001, 0, 0, 1);
        applyStimulus(4'b0010, 0, 0, 1);
        applyStimulus(4'b0100, 0, 0, 1);
        applyStimulus(4'b1000, 0, 0, 1);
        applyStimulus(4'b0001, 0, 0, 1);
        applyStimulus(4'b0001, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 1);
        checkOutput("t3_cnt", evt_cnt, 4);
        checkOutput("t3_ovf", evt_ovf, 1);
        checkOutput("t3_drop", drop_cnt, 1);
        applyStimulus(4'b0000, 1, 0, 1);
        checkOutput("t3_cnt_pushpop", evt_cnt, 4);
        applyStimulus(4'b0000, 1, 0, 4);
        checkOutput("t3_cnt_drained", evt_cnt, 0);
        applyStimulus(4'b0000, 0, 1, 1);
        checkOutput("t3_ovf_clr", evt_ovf, 0);
        checkOutput("t3_drop_clr", drop_cnt, 0);

        // push and pop together while full clears the waiting key
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(0); exp_q.push_back(1);
        applyStimulus(4'b0001, 0, 0, 1);
        applyStimulus(4'b0100, 0, 0, 1);
        applyStimulus(4'b1000, 0, 0, 1);
        applyStimulus(4'b0001, 0, 0, 1);
        applyStimulus(4'b0010, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 2);
        checkOutput("t4_cnt_full", evt_cnt, 4);
        applyStimulus(4'b0000, 1, 0, 1);
        checkOutput("t4_cnt_pushpop", evt_cnt, 4);
        applyStimulus(4'b0000, 0, 0, 2);
        checkOutput("t4_cnt_hold", evt_cnt, 4);
        applyStimulus(4'b0000, 1, 0, 4);
        checkOutput("t4_cnt_drained", evt_cnt, 0);
        applyStimulus(4'b0000, 1, 0, 2);
        checkOutput("t4_no_extra", evt_valid, 0);
        checkOutput("t4_ovf", evt_ovf, 0);

        // reset in the middle of a drain discards everything
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        applyStimulus(4'b0111, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 3);
        checkOutput("t5_cnt", evt_cnt, 3);
        applyStimulus(4'b0000, 1, 0, 1);
        checkOutput("t5_cnt_pop", evt_cnt, 2);
        clr = 1'b0;
        applyStimulus(4'b1000, 1, 0, 1);
        exp_q.delete();
        checkOutput("t5_valid", evt_valid, 0);
        checkOutput("t5_code", evt_code, 0);
        checkOutput("t5_cnt_rst", evt_cnt, 0);
        clr = 1'b1;
        applyStimulus(4'b0000, 1, 0, 3);
        checkOutput("t5_no_evt", evt_valid, 0);
        checkOutput("t5_cnt_after", evt_cnt, 0);

        // drop counter saturation and clear
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        applyStimulus(4'b1111, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 4);
        checkOutput("t6_cnt_full", evt_cnt, 4);
        applyStimulus(4'b1111, 0, 0, 1);
        checkOutput("t6_drop_none", drop_cnt, 0);
        checkOutput("t6_ovf_none", evt_ovf, 0);
        applyStimulus(4'b1111, 0, 0, 10);
        checkOutput("t6_drop_40", drop_cnt, 40);
        checkOutput("t6_ovf_set", evt_ovf, 1);
        applyStimulus(4'b1111, 0, 0, 65);
        checkOutput("t6_drop_sat", drop_cnt, 255);
        applyStimulus(4'b0011, 0, 1, 1);
        checkOutput("t6_loss_wins_drop", drop_cnt, 2);
        checkOutput("t6_loss_wins_ovf", evt_ovf, 1);
        applyStimulus(4'b0000, 0, 1, 1);
        checkOutput("t6_clr_drop", drop_cnt, 0);
        checkOutput("t6_clr_ovf", evt_ovf, 0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        applyStimulus(4'b0000, 1, 0, 8);
        checkOutput("t6_cnt_drained", evt_cnt, 0);
        applyStimulus(4'b0000, 0, 0, 1);

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
